nn_dense_stream_argmax: RTL and testbench
=========================================

// Module: nn_dense_stream_argmax
// PURPOSE
//  Sequential fixed-point dense layer using one time-multiplexed MAC. Holds weights/biases in a writable register array.
//  Takes one input vector as an element stream, emits one activation per neuron as a stream, and flags the argmax.
//  Successor to the combinational dense/softmax path; it is chained per layer and feeds classification output.
// PARAMETERS
//  IN_SIZE   4   elements per input vector (>=2)
//  OUT_SIZE  3   neurons (output elements) (>=2)
//  WIDTH     16  signed fixed-point data width
//  FRAC      8   fractional bits (Q(WIDTH-FRAC).FRAC)
//  ACT_RELU  1   1: ReLU on outputs; 0: identity
// PORTS
//  clk        in   1                           clock, all logic rising-edge
//  rst        in   1                           synchronous, active-high reset
//  wr_en      in   1                           parameter write strobe
//  wr_addr    in   $clog2(OUT_SIZE*(IN_SIZE+1)) addr = o*(IN_SIZE+1)+i (weight o,i); o*(IN_SIZE+1)+IN_SIZE (bias o)
//  wr_data    in   WIDTH                       signed weight/bias value
//  in_valid   in   1                           input element valid
//  in_ready   out  1                           input element accepted when valid&&ready
//  in_data    in   WIDTH                       signed input element
//  in_last    in   1                           marks last element of vector (checked only)
//  out_valid  out  1                           output element valid
//  out_ready  in   1                           output element consumed when valid&&ready
//  out_data   out  WIDTH                       activation of neuron out_idx
//  out_idx    out  $clog2(OUT_SIZE)            neuron index of out_data
//  out_last   out  1                           high on beat for neuron OUT_SIZE-1
//  argmax_idx out  $clog2(OUT_SIZE)            index of max activation; valid when out_last&&out_valid
//  busy       out  1                           high in MAC/BIAS/EMIT
//  err        out  2                           sticky: [0] in_last misplaced, [1] write while busy
// BEHAVIOUR
//  Reset (rst=1): state=LOAD, all counters 0. out_valid/out_last/busy/err = 0, out_data/out_idx/argmax_idx = 0.
//  in_ready = (state==LOAD) && !rst. Parameter array is NOT reset and is retained across reset.
//  FSM:
//   LOAD: each accepted element -> in_buf[cnt]; after IN_SIZE-th element -> MAC with neuron o=0
//   MAC:  IN_SIZE cycles, acc += in_buf[k]*W[o][k], acc cleared at entry -> BIAS
//   BIAS: 1 cycle; res = sat(ACT((acc + (B[o]<<<FRAC)) >>> FRAC)); register out beat -> EMIT
//   EMIT: out_valid=1, hold all out_* stable until out_ready; on handshake: o<OUT_SIZE-1 -> MAC(o+1), else -> LOAD
//  Latency: last input handshake -> first out_valid = IN_SIZE+1 cycles. Each out handshake -> next out_valid = IN_SIZE+1 cycles.
//  After the final out handshake, in_ready=1 on the next cycle. Input and output never overlap (single buffer).
//  Arithmetic:
//   product 2*WIDTH signed; ACC_W = 2*WIDTH+$clog2(IN_SIZE)+1, no overflow.
//   >>> FRAC is arithmetic shift (floor). Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//   ReLU is applied after saturation.
//  Argmax: running max over emitted results; strict '>' so ties keep lowest index; reset at each vector start.
//  in_last: if in_last != (cnt==IN_SIZE-1) on an accepted element, set err[0]. Vector length is always IN_SIZE.
//  Writes: accepted only when state==LOAD and cnt==0; otherwise dropped and err[1] set.
//  Out-of-range wr_addr is dropped without error.
//  rst mid-operation: abort at once; partial vector/results discarded; next vector processed with retained params.
//  err clears only on rst.
// STRUCTURE
//  Package nn_pkg: fixed_t (logic signed [WIDTH-1:0]), acc width function, sat_to_fixed() and relu() functions,
//  state enum {LOAD,MAC,BIAS,EMIT}.
//  Sub-module nn_mac_unit: signed multiply-accumulate with clr and en inputs, ACC_W accumulator, 1-cycle update.
//  Top: FSM, counters, param array (combinational read), in_buf, output/argmax regs.
// TESTING (IN_SIZE=4, OUT_SIZE=3, WIDTH=16, FRAC=8, 1.0=256)
//  1 Basic: W0=[256,0,0,0] B0=0; W1=[0,256,0,0] B1=256; W2=all -256 B2=0; in=[512,256,128,64]
//    -> out 512,512,0; argmax_idx=0 (tie); out_last on idx 2.
//  2 Saturation: all W=32767, B=0, in all 32767 -> every out = 32767.
//    ACT_RELU=0 with W=-32768 -> every out = -32768.
//  3 Truncation: ACT_RELU=0, W0=[1,0,0,0], in0=128 -> out0=0; in0=-128 -> out0=-1.
//  4 Backpressure: out_ready low 5 cycles on each beat -> out_data/out_idx stable, in_ready=0, no lost or duplicated beats.
//    Latency IN_SIZE+1 checked.
//  5 Reset in MAC of neuron 1 -> next cycle out_valid=0, busy=0, in_ready=1.
//    Resending test-1 vector -> same outputs 512,512,0.
//  6 Errors: in_last on 3rd element -> err=2'b01, outputs still correct.
//    wr_en during busy -> err[1]=1, weight unchanged on next vector.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the streaming dense layer.
// Provides the state enum, the accumulator width rule, saturation and ReLU.
package nn_pkg;

    localparam int FIX_W = 16;

    typedef logic signed [FIX_W-1:0] fixed_t;

    typedef enum logic [1:0] {
        LOAD,
        MAC,
        BIAS,
        EMIT
    } state_t;

    // Full-precision sum of IN_SIZE products plus one guard bit.
    function automatic int acc_width(input int width, input int in_size);
        return 2 * width + $clog2(in_size) + 1;
    endfunction

    // Clamp to the signed range of a width-bit two's complement value.
    function automatic logic signed [63:0] sat_to_fixed(
        input logic signed [63:0] v,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [63:0] relu(
        input logic signed [63:0] v
    );
        return (v < 0) ? 64'sd0 : v;
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Signed multiply-accumulate: acc <= acc + a*b when en, cleared by clr.
// Ports: clk, rst, clr, en, a, b (WIDTH signed), acc (ACC_W signed).
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = acc_width(16, 4)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*WIDTH-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/nn_dense_stream_argmax.sv
// Streaming fixed-point dense layer with one shared MAC and argmax flag.
// Ports: clk/rst, wr_* param writes, in_* element stream, out_* result stream, argmax_idx, busy, err.
module nn_dense_stream_argmax
    import nn_pkg::*;
#(
    parameter int IN_SIZE  = 4,
    parameter int OUT_SIZE = 3,
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int ACT_RELU = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wr_en,
    input  logic [$clog2(OUT_SIZE*(IN_SIZE+1))-1:0]  wr_addr,
    input  logic signed [WIDTH-1:0]                  wr_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic signed [WIDTH-1:0]                  in_data,
    input  logic                                     in_last,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic signed [WIDTH-1:0]                  out_data,
    output logic [$clog2(OUT_SIZE)-1:0]              out_idx,
    output logic                                     out_last,
    output logic [$clog2(OUT_SIZE)-1:0]              argmax_idx,
    output logic                                     busy,
    output logic [1:0]                               err
);

    localparam int NP    = OUT_SIZE * (IN_SIZE + 1);
    localparam int AW    = $clog2(NP);
    localparam int OW    = $clog2(OUT_SIZE);
    localparam int KW    = $clog2(IN_SIZE);
    localparam int ACC_W = acc_width(WIDTH, IN_SIZE);

    logic signed [WIDTH-1:0] prm    [NP];
    logic signed [WIDTH-1:0] in_buf [IN_SIZE];

    state_t            state;
    state_t            nxt;
    logic [KW-1:0]     cnt;
    logic [OW-1:0]     o;
    logic              last_r;
    logic signed [WIDTH-1:0] max_v;

    logic              in_fire;
    logic              out_fire;
    logic              cnt_last;
    logic              o_last;
    logic              wr_win;
    logic              wr_ok;

    logic [AW-1:0]     widx;
    logic [AW-1:0]     bidx;
    logic signed [WIDTH-1:0] mac_a;
    logic signed [WIDTH-1:0] mac_b;
    logic signed [WIDTH-1:0] bias_w;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] bsh;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shr;
    logic signed [63:0]      satv;
    logic signed [63:0]      actv;
    logic signed [WIDTH-1:0] res;

    assign in_ready  = (state == LOAD) && !rst;
    assign out_valid = (state == EMIT);
    assign out_last  = out_valid && last_r;
    assign busy      = (state != LOAD);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign cnt_last = (cnt == KW'(IN_SIZE - 1));
    assign o_last   = (o == OW'(OUT_SIZE - 1));

    // Parameters may only change between vectors, before any element arrives.
    assign wr_win = (state == LOAD) && (cnt == '0);
    assign wr_ok  = wr_en && wr_win && (int'(wr_addr) < NP);

    always_comb begin
        widx   = AW'(int'(o) * (IN_SIZE + 1) + int'(cnt));
        bidx   = AW'(int'(o) * (IN_SIZE + 1) + IN_SIZE);
        mac_a  = in_buf[cnt];
        mac_b  = prm[widx];
        bias_w = prm[bidx];
    end

    nn_mac_unit #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (state != MAC),
        .en  (state == MAC),
        .a   (mac_a),
        .b   (mac_b),
        .acc (acc)
    );

    // Bias is aligned to the product scale, then one floor shift back to Q.FRAC.
    always_comb begin
        bsh  = ACC_W'(bias_w) <<< FRAC;
        sum  = acc + bsh;
        shr  = sum >>> FRAC;
        satv = sat_to_fixed(64'(shr), WIDTH);
        actv = (ACT_RELU != 0) ? relu(satv) : satv;
        res  = actv[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            LOAD: if (in_fire && cnt_last) nxt = MAC;
            MAC:  if (cnt_last) nxt = BIAS;
            BIAS: nxt = EMIT;
            EMIT: if (out_fire) nxt = o_last ? LOAD : MAC;
            default: nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            prm[wr_addr] <= wr_data;
        end
        if (in_fire) begin
            in_buf[cnt] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            o          <= '0;
            out_data   <= '0;
            out_idx    <= '0;
            last_r     <= 1'b0;
            argmax_idx <= '0;
            max_v      <= '0;
            err        <= 2'b00;
        end else begin
            if (wr_en && !wr_win) begin
                err[1] <= 1'b1;
            end
            unique case (state)
                LOAD: begin
                    o <= '0;
                    if (in_fire) begin
                        if (in_last != cnt_last) begin
                            err[0] <= 1'b1;
                        end
                        cnt <= cnt_last ? '0 : cnt + 1'b1;
                    end
                end
                MAC: begin
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                end
                BIAS: begin
                    out_data <= res;
                    out_idx  <= o;
                    last_r   <= o_last;
                    // Neuron 0 restarts the running max for each vector.
                    if ((o == '0) || (res > max_v)) begin
                        max_v      <= res;
                        argmax_idx <= o;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        o <= o_last ? '0 : o + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_dense_stream_argmax.sv
// Directed bench for nn_dense_stream_argmax (ReLU and identity instances).
// Table vectors plus backpressure, reset-abort and error sequences.
module tb_nn_dense_stream_argmax;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic wr_en;
    logic [3:0] wr_addr;
    logic signed [15:0] wr_data;
    logic in_valid;
    logic in_last;
    logic signed [15:0] in_data;
    logic out_ready;

    logic r_in_ready, r_ov, r_ol, r_busy;
    logic signed [15:0] r_od;
    logic [1:0] r_oi, r_arg, r_err;
    logic i_in_ready, i_ov, i_ol, i_busy;
    logic signed [15:0] i_od;
    logic [1:0] i_oi, i_arg, i_err;

    nn_dense_stream_argmax #(
        .IN_SIZE(4), .OUT_SIZE(3), .WIDTH(16), .FRAC(8), .ACT_RELU(1)
    ) dut_r (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(r_in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(r_ov), .out_ready(out_ready),
        .out_data(r_od), .out_idx(r_oi), .out_last(r_ol),
        .argmax_idx(r_arg), .busy(r_busy), .err(r_err)
    );

    nn_dense_stream_argmax #(
        .IN_SIZE(4), .OUT_SIZE(3), .WIDTH(16), .FRAC(8), .ACT_RELU(0)
    ) dut_i (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(i_in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(i_ov), .out_ready(out_ready),
        .out_data(i_od), .out_idx(i_oi), .out_last(i_ol),
        .argmax_idx(i_arg), .busy(i_busy), .err(i_err)
    );

    typedef struct packed {
        logic [14:0][15:0] w;
        logic [3:0][15:0]  x;
        logic [2:0][15:0]  er;
        logic [2:0][15:0]  ei;
        logic [1:0]        ar;
        logic [1:0]        ai;
    } vec_t;

    vec_t tv [6];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setn(input int v, input int o, input int a, input int b,
                        input int c, input int d, input int bias);
        tv[v].w[o*5+0] = 16'(a);
        tv[v].w[o*5+1] = 16'(b);
        tv[v].w[o*5+2] = 16'(c);
        tv[v].w[o*5+3] = 16'(d);
        tv[v].w[o*5+4] = 16'(bias);
    endtask

    task automatic setx(input int v, input int a, input int b,
                        input int c, input int d);
        tv[v].x[0] = 16'(a);
        tv[v].x[1] = 16'(b);
        tv[v].x[2] = 16'(c);
        tv[v].x[3] = 16'(d);
    endtask

    task automatic sete(input int v, input int r0, input int r1, input int r2,
                        input int i0, input int i1, input int i2,
                        input int ar, input int ai);
        tv[v].er[0] = 16'(r0);
        tv[v].er[1] = 16'(r1);
        tv[v].er[2] = 16'(r2);
        tv[v].ei[0] = 16'(i0);
        tv[v].ei[1] = 16'(i1);
        tv[v].ei[2] = 16'(i2);
        tv[v].ar = 2'(ar);
        tv[v].ai = 2'(ai);
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic load(input int v);
        for (int k = 0; k < 15; k++) wr(k, tv[v].w[k]);
    endtask

    task automatic send(input int v, input int lp);
        int n;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data = tv[v].x[k];
            in_last = (k == lp);
            n = 0;
            while (!r_in_ready && n < 100) begin
                step();
                n++;
            end
            if (n >= 100) begin
                tests++;
                fails++;
                $display("FAIL in_timeout: got busy, want in_ready");
            end
            step();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic collect(input int v, input int hold, input int lat0);
        int lat;
        for (int o = 0; o < 3; o++) begin
            lat = 0;
            while (!r_ov && lat < 100) begin
                step();
                lat++;
            end
            chk("latency", lat, (o == 0) ? lat0 : 5);
            chk("data_relu", r_od, $signed(tv[v].er[o]));
            chk("data_id", i_od, $signed(tv[v].ei[o]));
            chk("idx", r_oi, o);
            chk("last", r_ol, (o == 2) ? 1 : 0);
            chk("valid_id", i_ov, 1);
            if (o == 2) begin
                chk("argmax_relu", r_arg, tv[v].ar);
                chk("argmax_id", i_arg, tv[v].ai);
            end
            for (int h = 0; h < hold; h++) begin
                step();
                chk("hold_valid", r_ov, 1);
                chk("hold_data", r_od, $signed(tv[v].er[o]));
                chk("hold_idx", r_oi, o);
                chk("hold_in_ready", r_in_ready, 0);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("in_ready_after", r_in_ready, 1);
        chk("busy_after", r_busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int lat;
        setn(0, 0, 256, 0, 0, 0, 0);
        setn(0, 1, 0, 256, 0, 0, 256);
        setn(0, 2, -256, -256, -256, -256, 0);
        setx(0, 512, 256, 128, 64);
        sete(0, 512, 512, 0, 512, 512, -960, 0, 0);
        for (int o = 0; o < 3; o++) setn(1, o, 32767, 32767, 32767, 32767, 0);
        setx(1, 32767, 32767, 32767, 32767);
        sete(1, 32767, 32767, 32767, 32767, 32767, 32767, 0, 0);
        for (int o = 0; o < 3; o++) setn(2, o, -32768, -32768, -32768, -32768, 0);
        setx(2, 32767, 32767, 32767, 32767);
        sete(2, 0, 0, 0, -32768, -32768, -32768, 0, 0);
        setn(3, 0, 1, 0, 0, 0, 0);
        setn(3, 1, 0, 0, 0, 0, -256);
        setn(3, 2, 0, 0, 0, 0, 256);
        setx(3, 128, 0, 0, 0);
        sete(3, 0, 0, 256, 0, -256, 256, 2, 2);
        tv[4] = tv[3];
        setx(4, -128, 0, 0, 0);
        sete(4, 0, 0, 256, -1, -256, 256, 2, 2);
        setn(5, 0, 256, 256, 0, 0, 0);
        setn(5, 1, 0, 0, 512, 0, 0);
        setn(5, 2, 0, 0, 0, -256, 512);
        setx(5, 256, -512, 384, 100);
        sete(5, 0, 768, 412, -256, 768, 412, 1, 1);

        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", r_in_ready, 0);
        chk("rst_out_valid", r_ov, 0);
        chk("rst_out_last", r_ol, 0);
        chk("rst_busy", r_busy, 0);
        chk("rst_err", r_err, 0);
        chk("rst_out_data", r_od, 0);
        chk("rst_out_idx", r_oi, 0);
        chk("rst_argmax", r_arg, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_idle", r_in_ready, 1);

        wr(15, 16'h1234);
        chk("oob_write_err", r_err, 0);

        for (int v = 0; v < 6; v++) begin
            load(v);
            send(v, 3);
            collect(v, 0, 5);
            chk("err_clean", r_err, 0);
        end

        load(0);
        send(0, 3);
        collect(0, 5, 5);

        send(0, 3);
        lat = 0;
        while (!r_ov && lat < 100) begin
            step();
            lat++;
        end
        chk("abort_first_lat", lat, 5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        step();
        chk("abort_busy_pre", r_busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_out_valid", r_ov, 0);
        chk("abort_busy", r_busy, 0);
        chk("abort_in_ready", r_in_ready, 1);
        send(0, 3);
        collect(0, 0, 5);

        send(0, 2);
        collect(0, 0, 5);
        chk("err_last", r_err, 1);

        send(0, 3);
        step();
        step();
        wr(0, 16'h0000);
        chk("err_busy_wr", r_err, 3);
        collect(0, 0, 2);
        send(0, 3);
        collect(0, 0, 5);
        chk("err_sticky", r_err, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
